// File: rtl/brew_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : brew_pkg
// Description : Shared types and constants for the brew sequencer: FSM state
//               encoding, actuator one-hot codes, drink codes and the recipe
//               ROM (one {valid, act, tcode} entry per drink and stage).
// Revision    : 1.0 - initial release
// ============================================================================
package brew_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ARM   = 3'd1,
        ST_WAIT  = 3'd2,
        ST_NEXT  = 3'd3,
        ST_DONE  = 3'd4,
        ST_FAULT = 3'd5
    } state_t;

    // Actuator one-hot codes, bit order matches the act port.
    localparam logic [4:0] ACT_NONE  = 5'b00000;
    localparam logic [4:0] ACT_HEAT  = 5'b00001;
    localparam logic [4:0] ACT_PUMP  = 5'b00010;
    localparam logic [4:0] ACT_WATER = 5'b00100;
    localparam logic [4:0] ACT_MILK  = 5'b01000;
    localparam logic [4:0] ACT_CHOC  = 5'b10000;

    localparam logic [1:0] DRINK_ESPRESSO   = 2'd0;
    localparam logic [1:0] DRINK_AMERICANO  = 2'd1;
    localparam logic [1:0] DRINK_CAPPUCCINO = 2'd2;
    localparam logic [1:0] DRINK_MOCHA      = 2'd3;

    typedef struct packed {
        logic       valid;
        logic [4:0] act;
        logic [1:0] tcode;
    } step_t;

    // Terminator: any index past the last stage of a recipe reads as this.
    localparam step_t STEP_END = '{valid: 1'b0, act: ACT_NONE, tcode: 2'd0};

    function automatic step_t mk_step(input logic [4:0] a, input logic [1:0] t);
        step_t s;
        s.valid = 1'b1;
        s.act   = a;
        s.tcode = t;
        return s;
    endfunction

    function automatic step_t recipe_step(input logic [1:0] drink, input logic [2:0] idx);
        step_t s;
        s = STEP_END;
        case (drink)
            DRINK_ESPRESSO: begin
                case (idx)
                    3'd0:    s = mk_step(ACT_HEAT, 2'd3);
                    3'd1:    s = mk_step(ACT_PUMP, 2'd2);
                    default: s = STEP_END;
                endcase
            end
            DRINK_AMERICANO: begin
                case (idx)
                    3'd0:    s = mk_step(ACT_HEAT,  2'd3);
                    3'd1:    s = mk_step(ACT_PUMP,  2'd2);
                    3'd2:    s = mk_step(ACT_WATER, 2'd1);
                    default: s = STEP_END;
                endcase
            end
            DRINK_CAPPUCCINO: begin
                case (idx)
                    3'd0:    s = mk_step(ACT_HEAT, 2'd3);
                    3'd1:    s = mk_step(ACT_PUMP, 2'd2);
                    3'd2:    s = mk_step(ACT_MILK, 2'd1);
                    default: s = STEP_END;
                endcase
            end
            default: begin // mocha
                case (idx)
                    3'd0:    s = mk_step(ACT_HEAT, 2'd3);
                    3'd1:    s = mk_step(ACT_CHOC, 2'd0);
                    3'd2:    s = mk_step(ACT_PUMP, 2'd2);
                    3'd3:    s = mk_step(ACT_MILK, 2'd1);
                    default: s = STEP_END;
                endcase
            end
        endcase
        return s;
    endfunction

    function automatic logic recipe_valid(input logic [1:0] drink, input logic [2:0] idx);
        step_t s;
        s = recipe_step(drink, idx);
        return s.valid;
    endfunction

endpackage

`default_nettype wire

// File: rtl/brew_watchdog.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : brew_watchdog
// Description : Per-stage watchdog. Counts enabled cycles since the last
//               clear and flags timeout on the enabled cycle in which the
//               count reaches WDOG_MAX.
// Ports       : clk, rst_n (async active-low), clear, enable -> timeout
// Revision    : 1.0 - initial release
// ============================================================================
module brew_watchdog
    import brew_pkg::*;
#(
    parameter int unsigned            WDOG_W   = 32,
    parameter logic [WDOG_W-1:0]      WDOG_MAX = 32'd1_500_000_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic timeout
);

    localparam logic [WDOG_W-1:0] LIMIT = WDOG_MAX - WDOG_W'(1);

    logic [WDOG_W-1:0] count;

    // Saturates at LIMIT so a stalled enable can never wrap back to zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && (count != LIMIT)) begin
            count <= count + WDOG_W'(1);
        end
    end

    assign timeout = enable && (count == LIMIT);

endmodule

`default_nettype wire

// File: rtl/brew_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : brew_sequencer
// Description : Brew controller. Latches a drink on a start edge and walks
//               its recipe stage by stage: program/start the timer, drive the
//               stage actuator, wait for (non-stale) expiry, break, repeat.
// Ports       : clk_100MHz, rst_n (async active-low)
//               start, cancel, drink_sel[1:0], timer_expired  (inputs)
//               timer_value[1:0], timer_start, act[4:0], stage[2:0],
//               busy, done, fault                              (outputs)
// Revision    : 1.0 - initial release
// ============================================================================
module brew_sequencer
    import brew_pkg::*;
#(
    parameter int unsigned        WDOG_W       = 32,
    parameter logic [WDOG_W-1:0]  WDOG_MAX     = 32'd1_500_000_000,
    parameter int unsigned        GUARD_CYCLES = 2
) (
    input  logic       clk_100MHz,
    input  logic       rst_n,
    input  logic       start,
    input  logic       cancel,
    input  logic [1:0] drink_sel,
    input  logic       timer_expired,
    output logic [1:0] timer_value,
    output logic       timer_start,
    output logic [4:0] act,
    output logic [2:0] stage,
    output logic       busy,
    output logic       done,
    output logic       fault
);

    localparam int unsigned          GUARD_W   = $clog2(GUARD_CYCLES + 2);
    localparam logic [GUARD_W-1:0]   GUARD_LIM = GUARD_W'(GUARD_CYCLES);

    state_t             state, state_d;
    logic               start_q, start_edge;
    logic [1:0]         drink_q;
    logic [2:0]         stage_q;
    logic [GUARD_W-1:0] guard_cnt;
    logic               seen_low;

    logic               latch, stage_inc;
    logic               wd_clear, wd_en, wd_timeout;
    logic               guard_ok, nxt_valid;
    step_t              cur_step;

    assign cur_step  = recipe_step(drink_q, stage_q);
    assign nxt_valid = recipe_valid(drink_q, stage_q + 3'd1);

    // Expiry is a level that may still be high from the previous stage, so
    // it only counts once the guard window has elapsed and it has been seen
    // low at least once since ARM.
    assign guard_ok = (guard_cnt == GUARD_LIM) && seen_low;

    brew_watchdog #(
        .WDOG_W   (WDOG_W),
        .WDOG_MAX (WDOG_MAX)
    ) u_wdog (
        .clk     (clk_100MHz),
        .rst_n   (rst_n),
        .clear   (wd_clear),
        .enable  (wd_en),
        .timeout (wd_timeout)
    );

    always_ff @(posedge clk_100MHz or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            start_q    <= 1'b0;
            start_edge <= 1'b0;
            drink_q    <= 2'd0;
            stage_q    <= 3'd0;
            guard_cnt  <= '0;
            seen_low   <= 1'b0;
        end else begin
            state      <= state_d;
            // Edge detector runs in every state so a start held through a
            // brew cannot retrigger when the FSM returns to IDLE.
            start_q    <= start;
            start_edge <= start & ~start_q;

            if (latch) begin
                drink_q <= drink_sel;
                stage_q <= 3'd0;
            end else if (stage_inc) begin
                stage_q <= stage_q + 3'd1;
            end

            if (state == ST_ARM) begin
                guard_cnt <= '0;
                seen_low  <= 1'b0;
            end else if (state == ST_WAIT) begin
                if (guard_cnt != GUARD_LIM) begin
                    guard_cnt <= guard_cnt + GUARD_W'(1);
                end
                if (!timer_expired) begin
                    seen_low <= 1'b1;
                end
            end
        end
    end

    always_comb begin
        state_d     = state;
        latch       = 1'b0;
        stage_inc   = 1'b0;
        wd_clear    = 1'b0;
        wd_en       = 1'b0;
        timer_start = 1'b0;
        timer_value = 2'd0;
        act         = ACT_NONE;
        busy        = 1'b0;
        done        = 1'b0;
        fault       = 1'b0;

        case (state)
            ST_IDLE: begin
                if (start_edge && !cancel) begin
                    latch   = 1'b1;
                    state_d = ST_ARM;
                end
            end
            ST_ARM: begin
                busy        = 1'b1;
                timer_start = cur_step.valid;
                timer_value = cur_step.tcode;
                act         = cur_step.act;
                wd_clear    = 1'b1;
                state_d     = cancel ? ST_IDLE : ST_WAIT;
            end
            ST_WAIT: begin
                busy        = 1'b1;
                timer_value = cur_step.tcode;
                act         = cur_step.act;
                wd_en       = 1'b1;
                if (cancel) begin
                    state_d = ST_IDLE;
                end else if (guard_ok && timer_expired) begin
                    state_d = ST_NEXT;
                end else if (wd_timeout) begin
                    state_d = ST_FAULT;
                end
            end
            ST_NEXT: begin
                // Actuators stay off for this cycle: break-before-make.
                busy = 1'b1;
                if (cancel) begin
                    state_d = ST_IDLE;
                end else if (nxt_valid) begin
                    stage_inc = 1'b1;
                    state_d   = ST_ARM;
                end else begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                busy    = 1'b1;
                done    = 1'b1;
                state_d = ST_IDLE;
            end
            ST_FAULT: begin
                fault = 1'b1;
                if (cancel) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign stage = stage_q;

endmodule

`default_nettype wire
